// File: rtl/conveyor_pkg.sv
// Shared types and constants for the multi-lane conveyor safety controller.
// The lane state codes appear directly on lane_state_o, so the enum is pinned to them.
package conveyor_pkg;

  localparam logic [1:0] CODE_NORMAL = 2'd0;
  localparam logic [1:0] CODE_WARN   = 2'd1;
  localparam logic [1:0] CODE_CRIT   = 2'd2;

  typedef enum logic [1:0] {
    NORMAL = CODE_NORMAL,
    WARN   = CODE_WARN,
    CRIT   = CODE_CRIT
  } lane_state_t;

  // Counter/index width for a range of n values, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conveyor_lane_fsm.sv
// One conveyor lane: warning/critical debouncers, WARN escalation timer and
// the NORMAL/WARN/CRIT Moore machine with operator-acknowledged CRIT latch.
module conveyor_lane_fsm
  import conveyor_pkg::*;
#(
  parameter int DEB_CYC = 4,
  parameter int ESC_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        warn_raw,
  input  logic        crit_raw,
  input  logic        ack,
  output lane_state_t state,
  output logic        crit_next,
  output logic        is_normal,
  output logic        is_warn,
  output logic        is_crit
);

  localparam int DW = cnt_width(DEB_CYC);
  localparam int EW = cnt_width(ESC_CYC);

  logic [1:0]    raw;
  logic [1:0]    deb;
  logic [DW-1:0] deb_cnt [2];
  logic          warn_d;
  logic          crit_d;
  logic [EW-1:0] esc_cnt;
  logic          esc_done;
  lane_state_t   state_next;

  assign raw    = {crit_raw, warn_raw};
  assign warn_d = deb[0];
  assign crit_d = deb[1];

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= '0;
      // NOTE: the counter array is reset along with everything else; a reset
      // must discard partial debounce progress, so this is not a free memory.
      for (int b = 0; b < 2; b++) deb_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (raw[b] == deb[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DW'(DEB_CYC - 1)) begin
          deb[b]     <= raw[b];
          deb_cnt[b] <= '0;
        end else begin
          deb_cnt[b] <= deb_cnt[b] + DW'(1);
        end
      end
    end
  end

  assign esc_done = (esc_cnt == EW'(ESC_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= NORMAL;
      esc_cnt <= '0;
    end else begin
      state   <= state_next;
      esc_cnt <= (state == WARN && state_next == WARN) ? esc_cnt + EW'(1) : '0;
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      NORMAL: begin
        if (crit_d)      state_next = CRIT;
        else if (warn_d) state_next = WARN;
      end
      WARN: begin
        if (crit_d || esc_done) state_next = CRIT;
        else if (!warn_d)       state_next = NORMAL;
      end
      CRIT: begin
        if (ack && !crit_d) state_next = warn_d ? WARN : NORMAL;
      end
      default: state_next = NORMAL;
    endcase
  end

  always_comb begin
    is_normal = (state == NORMAL);
    is_warn   = (state == WARN);
    is_crit   = (state == CRIT);
    crit_next = (state_next == CRIT);
  end

endmodule

// File: rtl/conveyor_safety_ctrl.sv
// Multi-lane conveyor safety controller: per-lane FSMs, shared emergency output,
// optional global sort stop and first-fault lane capture.
module conveyor_safety_ctrl
  import conveyor_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int DEB_CYC     = 4,
  parameter int ESC_CYC     = 16,
  parameter int GLOBAL_STOP = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [LANES-1:0]              warn_i,
  input  logic [LANES-1:0]              crit_i,
  input  logic                          ack_i,
  output logic [LANES-1:0]              o_sort,
  output logic [LANES-1:0]              o_warn,
  output logic                          o_emg,
  output logic [2*LANES-1:0]            lane_state_o,
  output logic [cnt_width(LANES)-1:0]   first_fault_o
);

  localparam int  FW          = cnt_width(LANES);
  localparam bit  STOP_ALL_EN = (GLOBAL_STOP != 0);

  lane_state_t      lane_st [LANES];
  logic [LANES-1:0] is_normal;
  logic [LANES-1:0] is_warn;
  logic [LANES-1:0] is_crit;
  logic [LANES-1:0] crit_next;
  logic [FW-1:0]    ff_load;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    conveyor_lane_fsm #(
      .DEB_CYC (DEB_CYC),
      .ESC_CYC (ESC_CYC)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .warn_raw  (warn_i[i]),
      .crit_raw  (crit_i[i]),
      .ack       (ack_i),
      .state     (lane_st[i]),
      .crit_next (crit_next[i]),
      .is_normal (is_normal[i]),
      .is_warn   (is_warn[i]),
      .is_crit   (is_crit[i])
    );
    assign lane_state_o[2*i +: 2] = lane_st[i];
  end

  assign o_emg  = |is_crit;
  assign o_warn = is_warn;
  assign o_sort = is_normal & ~{LANES{STOP_ALL_EN && o_emg}};

  // Lowest-index lane among those in CRIT after this edge.
  always_comb begin
    ff_load = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (crit_next[i]) ff_load = FW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                first_fault_o <= '0;
    else if (!(|crit_next)) first_fault_o <= '0;
    else if (!o_emg)        first_fault_o <= ff_load;
  end

endmodule

// File: tb/tb_conveyor_safety_ctrl.sv
// Directed bench for conveyor_safety_ctrl: a GLOBAL_STOP=1 and a GLOBAL_STOP=0
// instance share stimulus and are compared each cycle against a lane-level model.
module tb_conveyor_safety_ctrl;

  localparam int LANES   = 4;
  localparam int DEB_CYC = 4;
  localparam int ESC_CYC = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [LANES-1:0] warn_i = '0;
  logic [LANES-1:0] crit_i = '0;
  logic             ack_i  = 1'b0;

  logic [LANES-1:0]   sort_g, warn_g, sort_l, warn_l;
  logic               emg_g, emg_l;
  logic [2*LANES-1:0] ls_g, ls_l;
  logic [1:0]         ff_g, ff_l;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  always #5 clk = ~clk;

  conveyor_safety_ctrl #(.LANES(LANES), .DEB_CYC(DEB_CYC), .ESC_CYC(ESC_CYC), .GLOBAL_STOP(1)) dut_g (
    .clk(clk), .rst(rst), .warn_i(warn_i), .crit_i(crit_i), .ack_i(ack_i),
    .o_sort(sort_g), .o_warn(warn_g), .o_emg(emg_g), .lane_state_o(ls_g), .first_fault_o(ff_g)
  );

  conveyor_safety_ctrl #(.LANES(LANES), .DEB_CYC(DEB_CYC), .ESC_CYC(ESC_CYC), .GLOBAL_STOP(0)) dut_l (
    .clk(clk), .rst(rst), .warn_i(warn_i), .crit_i(crit_i), .ack_i(ack_i),
    .o_sort(sort_l), .o_warn(warn_l), .o_emg(emg_l), .lane_state_o(ls_l), .first_fault_o(ff_l)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: state 0/1/2 per lane, debounced level = raw level once it has
  // differed for DEB_CYC consecutive samples, escalation by elapsed cycles.
  int m_st    [LANES];
  int m_new   [LANES];
  int m_dw    [LANES];
  int m_dc    [LANES];
  int m_rw    [LANES];
  int m_rc    [LANES];
  int m_since [LANES];
  int m_ff  = 0;
  int m_cyc = 0;

  initial begin
    for (int i = 0; i < LANES; i++) begin
      m_st[i] = 0; m_dw[i] = 0; m_dc[i] = 0; m_rw[i] = 0; m_rc[i] = 0; m_since[i] = 0;
    end
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < LANES; i++) begin
          m_st[i] = 0; m_dw[i] = 0; m_dc[i] = 0; m_rw[i] = 0; m_rc[i] = 0; m_since[i] = 0;
        end
        m_ff = 0;
      end else begin
        bit prev_any, new_any;
        prev_any = 0; new_any = 0;
        for (int i = 0; i < LANES; i++) begin
          if (m_st[i] == 2) prev_any = 1;
          m_new[i] = m_st[i];
          if (m_st[i] == 0) begin
            m_new[i] = m_dc[i] ? 2 : (m_dw[i] ? 1 : 0);
          end else if (m_st[i] == 1) begin
            if (m_dc[i] != 0 || m_cyc - m_since[i] >= ESC_CYC) m_new[i] = 2;
            else if (m_dw[i] == 0) m_new[i] = 0;
          end else if (ack_i && m_dc[i] == 0) begin
            m_new[i] = m_dw[i] ? 1 : 0;
          end
          if (m_new[i] == 1 && m_st[i] != 1) m_since[i] = m_cyc;
          if (int'(warn_i[i]) != m_dw[i]) begin
            m_rw[i]++;
            if (m_rw[i] == DEB_CYC) begin m_dw[i] = int'(warn_i[i]); m_rw[i] = 0; end
          end else m_rw[i] = 0;
          if (int'(crit_i[i]) != m_dc[i]) begin
            m_rc[i]++;
            if (m_rc[i] == DEB_CYC) begin m_dc[i] = int'(crit_i[i]); m_rc[i] = 0; end
          end else m_rc[i] = 0;
        end
        for (int i = LANES - 1; i >= 0; i--) begin
          m_st[i] = m_new[i];
          if (m_new[i] == 2) new_any = 1;
        end
        if (!new_any) m_ff = 0;
        else if (!prev_any) begin
          for (int i = LANES - 1; i >= 0; i--) if (m_new[i] == 2) m_ff = i;
        end
      end
      m_cyc++;
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        logic [LANES-1:0]   e_norm, e_warn;
        logic [2*LANES-1:0] e_ls;
        logic               e_emg;
        e_emg = 1'b0;
        for (int i = 0; i < LANES; i++) begin
          e_norm[i]       = (m_st[i] == 0);
          e_warn[i]       = (m_st[i] == 1);
          e_ls[2*i +: 2]  = 2'(m_st[i]);
          if (m_st[i] == 2) e_emg = 1'b1;
        end
        check("m_sort_g",  32'(sort_g), 32'(e_emg ? '0 : e_norm));
        check("m_sort_l",  32'(sort_l), 32'(e_norm));
        check("m_warn_g",  32'(warn_g), 32'(e_warn));
        check("m_warn_l",  32'(warn_l), 32'(e_warn));
        check("m_emg_g",   32'(emg_g),  32'(e_emg));
        check("m_emg_l",   32'(emg_l),  32'(e_emg));
        check("m_state_g", 32'(ls_g),   32'(e_ls));
        check("m_state_l", 32'(ls_l),   32'(e_ls));
        check("m_ff_g",    32'(ff_g),   32'(m_ff));
        check("m_ff_l",    32'(ff_l),   32'(m_ff));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack_pulse();
    ack_i = 1'b1;
    step(1);
    ack_i = 1'b0;
  endtask

  initial begin
    step(2);
    rst    = 1'b0;
    cmp_en = 1'b1;
    check("rst_sort",  32'(sort_g), 32'hF);
    check("rst_state", 32'(ls_g),   32'h00);
    check("rst_ff",    32'(ff_g),   32'h0);

    // Idle
    step(20);
    check("idle_sort", 32'(sort_g), 32'hF);
    check("idle_emg",  32'(emg_g),  32'h0);

    // Short warning pulse, then a held warning on lane 1
    warn_i[1] = 1'b1; step(3); warn_i[1] = 1'b0; step(6);
    check("pulse_warn", 32'(warn_g), 32'h0);
    warn_i[1] = 1'b1; step(4);
    check("warn_lat4", 32'(warn_g), 32'h0);
    step(1);
    check("warn_lat5",   32'(warn_g), 32'h2);
    check("warn_sort",   32'(sort_g), 32'hD);
    check("warn_state",  32'(ls_g),   32'h04);
    warn_i[1] = 1'b0; step(4);
    check("rel_lat4", 32'(warn_g), 32'h2);
    step(1);
    check("rel_lat5", 32'(warn_g), 32'h0);

    // Escalation on lane 2
    warn_i[2] = 1'b1; step(5);
    check("esc_warn", 32'(ls_g), 32'h10);
    step(15);
    check("esc_pre", 32'(ls_g), 32'h10);
    step(1);
    check("esc_state", 32'(ls_g),   32'h20);
    check("esc_emg",   32'(emg_g),  32'h1);
    check("esc_sort",  32'(sort_g), 32'h0);
    check("esc_sortl", 32'(sort_l), 32'hB);
    check("esc_ff",    32'(ff_g),   32'h2);
    check("esc_warn2", 32'(warn_g), 32'h0);
    warn_i[2] = 1'b0; step(6); ack_pulse(); step(1);
    check("esc_clr", 32'(ls_g), 32'h00);

    // Simultaneous criticals on lanes 0 and 3
    crit_i[0] = 1'b1; crit_i[3] = 1'b1; step(5);
    check("dual_state", 32'(ls_g), 32'h82);
    check("dual_ff",    32'(ff_g), 32'h0);
    crit_i[0] = 1'b0; step(5); ack_pulse(); step(1);
    check("dual_ack",   32'(ls_g),  32'h80);
    check("dual_emg",   32'(emg_g), 32'h1);
    check("dual_ff2",   32'(ff_g),  32'h0);
    crit_i[3] = 1'b0; step(6);
    check("noqueue", 32'(ls_g), 32'h80);
    ack_pulse(); step(1);
    check("dual_clr", 32'(emg_g), 32'h0);

    // Warning and critical together: CRIT wins
    warn_i[0] = 1'b1; crit_i[0] = 1'b1; step(5);
    check("both_state", 32'(ls_g), 32'h02);
    warn_i[0] = 1'b0; crit_i[0] = 1'b0; step(5); ack_pulse(); step(1);
    check("both_clr", 32'(ls_g), 32'h00);

    // Reset mid-operation with critical still asserted
    crit_i[1] = 1'b1; step(5);
    check("rst_crit", 32'(ls_g), 32'h08);
    check("rst_ff1",  32'(ff_g), 32'h1);
    rst = 1'b1; step(1); rst = 1'b0;
    check("rst_mid_state", 32'(ls_g),  32'h00);
    check("rst_mid_emg",   32'(emg_g), 32'h0);
    step(4);
    check("requal4", 32'(ls_g), 32'h00);
    step(1);
    check("requal5", 32'(ls_g), 32'h08);
    crit_i[1] = 1'b0; step(5); ack_pulse(); step(1);

    // Lane-local stop, then ack into WARN
    crit_i[1] = 1'b1; step(5);
    check("ls_sort",  32'(sort_l), 32'hD);
    check("ls_emg",   32'(emg_l),  32'h1);
    check("gs_sort",  32'(sort_g), 32'h0);
    crit_i[1] = 1'b0; warn_i[1] = 1'b1; step(5); ack_pulse();
    check("ls_state", 32'(ls_l),   32'h04);
    check("ls_warn",  32'(warn_l), 32'h2);
    check("ls_emg0",  32'(emg_l),  32'h0);
    warn_i[1] = 1'b0; step(8);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conveyor_safety_ctrl.md
Name: conveyor_safety_ctrl

Overview:
Multi-lane successor to the single-lane smart conveyor FSM. It runs one NORMAL/WARN/CRIT state machine per lane, with debounced warning/critical sensor inputs and time-based escalation from WARN to CRIT. CRIT is latched until an operator acknowledge. The block drives the per-lane sort motor/piston, the per-lane warning LED/fan, and a shared emergency buzzer/brake. It sits between the sensor front-end and the actuator drivers.

Parameters:
LANES, 4, number of conveyor lanes (1..16)
DEB_CYC, 4, consecutive cycles a raw input must hold a new level before the debounced level changes (>=1)
ESC_CYC, 16, cycles continuously in WARN before forced escalation to CRIT (>=1)
GLOBAL_STOP, 1, 1: any CRIT lane stops sorting on all lanes; 0: only the faulted lane stops

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
warn_i  in  LANES  raw warning sensor per lane (A)
crit_i  in  LANES  raw critical sensor per lane (C)
ack_i  in  1  operator acknowledge, level-sensitive
o_sort  out  LANES  motor and piston enable per lane
o_warn  out  LANES  LED and fan per lane
o_emg  out  1  buzzer and brake
lane_state_o  out  2*LANES  per-lane state code: 0 = NORMAL, 1 = WARN, 2 = CRIT
first_fault_o  out  max(1,$clog2(LANES))  index of the lane that triggered the current emergency

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- All state is updated on the rising edge of clk. rst takes priority over every other event.
- Reset values: all lanes NORMAL; debounced levels 0; all counters 0. This gives o_sort = all 1s, o_warn = 0, o_emg = 0, lane_state_o = 0, first_fault_o = 0.
- Debounce, per input bit:
  - A counter increments each cycle that raw != debounced level.
  - The counter clears to 0 on any cycle where raw == debounced level.
  - When the counter equals DEB_CYC-1 and raw still differs, the debounced level toggles at that edge and the counter clears.
  - Pulses shorter than DEB_CYC cycles are ignored.
- Lane FSM. It is Moore, and its inputs are the debounced signals crit_d and warn_d.
  - NORMAL: crit_d -> CRIT; else warn_d -> WARN; else stay.
  - WARN:
    - crit_d -> CRIT.
    - else escalation counter == ESC_CYC-1 -> CRIT.
    - else !warn_d -> NORMAL.
    - else stay and increment the escalation counter.
    - The escalation counter clears on every entry to WARN.
  - CRIT (latched):
    - Leaves only when ack_i == 1 and crit_d == 0.
    - Goes to WARN if warn_d is set, otherwise to NORMAL.
    - ack_i with crit_d still high: no effect, no queuing.
    - ack_i outside CRIT is ignored.
- Latency: a raw edge held steady appears as a state/output change exactly DEB_CYC+1 rising edges after it is first sampled.
- Outputs, decoded combinationally from the registered state:
  - o_warn[i] = (lane i in WARN).
  - o_emg = OR over lanes of (state == CRIT).
  - o_sort[i] = (lane i in NORMAL) and !(GLOBAL_STOP and o_emg).
- first_fault_o:
  - Loads on the edge where at least one lane enters CRIT while no lane was in CRIT.
  - If several lanes enter CRIT on that edge, it takes the lowest index.
  - It then holds until o_emg deasserts, at which point it returns to 0.
- Simultaneous events:
  - crit_d and warn_d together: CRIT wins.
  - Escalation and warn_d falling on the same edge: escalation wins.
- Reset mid-operation: rst clears latched CRIT and discards debounce progress. An input still asserted must qualify again over the full DEB_CYC.

Decomposition:
- Package conveyor_pkg holds:
  - lane_state_t enum: NORMAL = 2'd0, WARN = 2'd1, CRIT = 2'd2.
  - The state-code constants used by lane_state_o.
- Sub-module conveyor_lane_fsm holds one lane's two debouncers, its escalation counter and its FSM. Parameters: DEB_CYC, ESC_CYC.
- The top level holds:
  - a generate loop of LANES instances;
  - the o_emg reduction;
  - the GLOBAL_STOP gating;
  - the first_fault priority encoder and register.

Test Plan:
Defaults: LANES=4, DEB_CYC=4, ESC_CYC=16.
1. Reset, then all inputs 0 for 20 cycles -> o_sort=4'hF, o_warn=0, o_emg=0, lane_state_o=0 throughout.
2. warn_i[1] pulse of 3 cycles -> no change. warn_i[1] held -> exactly 5 edges later o_warn=4'b0010, o_sort=4'b1101. Release -> back to NORMAL 5 edges after release.
3. warn_i[2] held indefinitely -> WARN after 5 edges, CRIT 16 edges later. Then o_emg=1, o_sort=0, first_fault_o=2, o_warn[2]=0.
4. crit_i[0] and crit_i[3] asserted in the same cycle -> first_fault_o=0. Then release crit_i[0] only and pulse ack_i -> lane 0 to NORMAL, lane 3 stays CRIT, o_emg=1, first_fault_o stays 0.
5. Lane 1 in CRIT with crit_i[1] still high; rst pulsed for 1 cycle -> next edge all NORMAL, o_emg=0. CRIT re-enters exactly 5 edges after rst deasserts.
6. GLOBAL_STOP=0 build, crit_i[1] held -> o_sort=4'b1101, o_emg=1. ack_i with crit_i[1] low and warn_i[1] high -> lane 1 to WARN, o_warn=4'b0010, o_emg=0.
